// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle RV64 core: opcode encodings, control FSM state
// encoding, ALU-op / writeback-select / trap-cause codes, and an opcode legality helper
// used by both the control FSM and immgen.
package cpu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StBranch,
    StJal,
    StTrap
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // Only BEQ/BNE are implemented among the branch funct3 encodings.
  function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
    logic ok;
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_JAL: ok = 1'b1;
      OPC_BRANCH:                           ok = (f3 == F3_BEQ) || (f3 == F3_BNE);
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV64 core.
// Sequences FETCH/DECODE/EXEC/MEM/WB (plus BRANCH and JAL) and halts in TRAP on an illegal
// opcode or a memory-handshake timeout.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_opcode, i_funct3      IR fields, sampled only in DECODE
//   i_alu_zero              ALU zero flag, used in BRANCH
//   i_mem_ready             memory completes the current request
//   o_mem_req, o_mem_we     unified memory port request / store
//   o_ir_write, o_imm_en    IR load strobe, immgen capture strobe
//   o_alu_src, o_alu_op     ALU operand select and operation class
//   o_reg_write, o_mem_to_reg  regfile write enable and writeback source
//   o_pc_write, o_pc_src    PC update enable and next-value select
//   o_trap, o_trap_cause    sticky halt flag and its cause
//   o_instret               retired-instruction counter (wraps)
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic             i_alu_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_ir_write,
  output logic             o_imm_en,
  output logic             o_alu_src,
  output logic [1:0]       o_alu_op,
  output logic             o_reg_write,
  output logic [1:0]       o_mem_to_reg,
  output logic             o_pc_write,
  output logic             o_pc_src,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_instret
);

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e           r_state, w_state_d;
  logic [6:0]       r_op;
  logic [2:0]       r_f3;
  logic [7:0]       r_wait_cnt, w_wait_cnt_d;
  logic             r_trap;
  logic [1:0]       r_trap_cause, w_trap_cause_d;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire, w_mem_phase, w_timeout, w_taken;

  assign w_mem_phase = (r_state == StFetch) || (r_state == StMem);
  // A completing handshake on the last allowed cycle wins over the timeout.
  assign w_timeout   = w_mem_phase && !i_mem_ready && (r_wait_cnt == WaitLast);
  assign w_taken     = (r_f3 == F3_BEQ) ? i_alu_zero : !i_alu_zero;

  always_comb begin : next_state
    w_state_d      = r_state;
    w_trap_cause_d = r_trap_cause;
    w_retire       = 1'b0;
    unique case (r_state)
      StIdle:  w_state_d = StFetch;
      StFetch: begin
        if (i_mem_ready) begin
          w_state_d = StDecode;
        end else if (w_timeout) begin
          w_state_d      = StTrap;
          w_trap_cause_d = TRAP_TIMEOUT;
        end
      end
      StDecode: begin
        if (!is_legal(i_opcode, i_funct3)) begin
          w_state_d      = StTrap;
          w_trap_cause_d = TRAP_ILLEGAL;
        end else if (i_opcode == OPC_BRANCH) begin
          w_state_d = StBranch;
        end else if (i_opcode == OPC_JAL) begin
          w_state_d = StJal;
        end else begin
          w_state_d = StExec;
        end
      end
      StExec: w_state_d = (r_op == OPC_OP) ? StWb : StMem;
      StMem: begin
        if (i_mem_ready) begin
          if (r_op == OPC_STORE) begin
            w_state_d = StFetch;
            w_retire  = 1'b1;
          end else begin
            w_state_d = StWb;
          end
        end else if (w_timeout) begin
          w_state_d      = StTrap;
          w_trap_cause_d = TRAP_TIMEOUT;
        end
      end
      StWb, StBranch, StJal: begin
        w_state_d = StFetch;
        w_retire  = 1'b1;
      end
      StTrap:  w_state_d = StTrap;
      default: w_state_d = StIdle;
    endcase
  end

  // Counts consecutive stalled cycles; any completion or state change restarts it.
  always_comb begin : wait_next
    w_wait_cnt_d = '0;
    if (w_mem_phase && !i_mem_ready && (w_state_d == r_state)) begin
      w_wait_cnt_d = r_wait_cnt + 8'd1;
    end
  end

  always_comb begin : ctrl_out
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_ir_write   = 1'b0;
    o_imm_en     = 1'b0;
    o_alu_src    = 1'b0;
    o_alu_op     = ALU_ADD;
    o_reg_write  = 1'b0;
    o_mem_to_reg = M2R_ALU;
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    unique case (r_state)
      StFetch: begin
        o_mem_req  = 1'b1;
        o_ir_write = i_mem_ready;
        o_pc_write = i_mem_ready;
      end
      StDecode: o_imm_en = 1'b1;
      StExec: begin
        if (r_op == OPC_OP) begin
          o_alu_op = ALU_FUNCT;
        end else begin
          o_alu_src = 1'b1;
        end
      end
      StMem: begin
        o_mem_req = 1'b1;
        o_mem_we  = (r_op == OPC_STORE);
      end
      StWb: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = (r_op == OPC_LOAD) ? M2R_MEM : M2R_ALU;
      end
      StBranch: begin
        o_alu_op   = ALU_SUB;
        o_pc_write = w_taken;
        o_pc_src   = 1'b1;
      end
      StJal: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = M2R_PC4;
        o_pc_write   = 1'b1;
        o_pc_src     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_wait_cnt   <= '0;
      r_instret    <= '0;
      r_trap       <= 1'b0;
      r_trap_cause <= TRAP_NONE;
      r_op         <= '0;
      r_f3         <= '0;
    end else begin
      r_state      <= w_state_d;
      r_wait_cnt   <= w_wait_cnt_d;
      r_trap_cause <= w_trap_cause_d;
      if (w_state_d == StTrap) r_trap <= 1'b1;
      if (r_state == StDecode) begin
        r_op <= i_opcode;
        r_f3 <= i_funct3;
      end
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign o_trap       = r_trap;
  assign o_trap_cause = r_trap_cause;
  assign o_instret    = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded into the
// per-cycle control pattern it should produce (fetch stalls, decode, execute, memory
// stalls, writeback), with memory wait lengths and operands chosen at random.
module tb_multicycle_control;
  import cpu_pkg::*;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [6:0]      opcode = '0;
  logic [2:0]      funct3 = '0;
  logic            alu_zero = 1'b0;
  logic            mem_ready = 1'b0;
  logic            o_mem_req, o_mem_we, o_ir_write, o_imm_en, o_alu_src;
  logic [1:0]      o_alu_op, o_mem_to_reg, o_trap_cause;
  logic            o_reg_write, o_pc_write, o_pc_src, o_trap;
  logic [CntW-1:0] o_instret;

  always #5 clk = ~clk;

  multicycle_control #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_opcode    (opcode),
    .i_funct3    (funct3),
    .i_alu_zero  (alu_zero),
    .i_mem_ready (mem_ready),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_ir_write  (o_ir_write),
    .o_imm_en    (o_imm_en),
    .o_alu_src   (o_alu_src),
    .o_alu_op    (o_alu_op),
    .o_reg_write (o_reg_write),
    .o_mem_to_reg(o_mem_to_reg),
    .o_pc_write  (o_pc_write),
    .o_pc_src    (o_pc_src),
    .o_trap      (o_trap),
    .o_trap_cause(o_trap_cause),
    .o_instret   (o_instret)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       imm_en;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       pc_write;
    logic       pc_src;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  ctl_t obs;
  assign obs = {o_mem_req, o_mem_we, o_ir_write, o_imm_en, o_alu_src, o_alu_op, o_reg_write,
                o_mem_to_reg, o_pc_write, o_pc_src, o_trap, o_trap_cause};

  int n_pass  = 0;
  int n_total = 0;
  int retired = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
  endtask

  // One clock: drive inputs, compare on the falling edge, advance past the rising edge.
  task automatic cyc(input logic rdy, input logic [6:0] opc, input logic [2:0] f3,
                     input logic zero, input ctl_t want, input string tag);
    mem_ready = rdy;
    opcode    = opc;
    funct3    = f3;
    alu_zero  = zero;
    @(negedge clk);
    check(tag, 64'(obs), 64'(want));
    @(posedge clk);
    #1;
  endtask

  // Same, with IR fields and the zero flag scrambled: they must not matter here.
  task automatic cycj(input logic rdy, input ctl_t want, input string tag);
    cyc(rdy, 7'($urandom), 3'($urandom), 1'($urandom), want, tag);
  endtask

  function automatic ctl_t fetch_c(input logic done);
    ctl_t c = '0;
    c.mem_req  = 1'b1;
    c.ir_write = done;
    c.pc_write = done;
    return c;
  endfunction

  function automatic ctl_t trap_c(input logic [1:0] cause);
    ctl_t c = '0;
    c.trap       = 1'b1;
    c.trap_cause = cause;
    return c;
  endfunction

  function automatic logic [63:0] exp_instret();
    return 64'(retired % (1 << CntW));
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    retired = 0;
    check("rst_outputs", 64'(obs), 64'(0));
    check("rst_instret", 64'(o_instret), exp_instret());
    rst = 1'b0;
    cycj(1'b1, '0, "idle");
  endtask

  task automatic fetch_decode(input logic [6:0] opc, input logic [2:0] f3, input int wf);
    ctl_t c;
    for (int i = 0; i < wf; i++) cycj(1'b0, fetch_c(1'b0), "fetch_wait");
    cycj(1'b1, fetch_c(1'b1), "fetch_done");
    c = '0;
    c.imm_en = 1'b1;
    cyc(1'($urandom), opc, f3, 1'($urandom), c, "decode");
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic zero,
                           input int wf, input int wm);
    ctl_t c;
    fetch_decode(opc, f3, wf);
    c = '0;
    if (opc == OPC_LOAD || opc == OPC_STORE) begin
      c.alu_src = 1'b1;
      c.alu_op  = 2'b00;
      cycj(1'($urandom), c, "exec_addr");
      c = '0;
      c.mem_req = 1'b1;
      c.mem_we  = (opc == OPC_STORE);
      for (int i = 0; i < wm; i++) cycj(1'b0, c, "mem_wait");
      cycj(1'b1, c, "mem_done");
      if (opc == OPC_LOAD) begin
        c = '0;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b01;
        cycj(1'($urandom), c, "wb_load");
      end
    end else if (opc == OPC_OP) begin
      c.alu_op = 2'b10;
      cycj(1'($urandom), c, "exec_op");
      c = '0;
      c.reg_write = 1'b1;
      cycj(1'($urandom), c, "wb_op");
    end else if (opc == OPC_BRANCH) begin
      c.alu_op   = 2'b01;
      c.pc_src   = 1'b1;
      c.pc_write = (f3 == 3'b000) ? zero : !zero;
      cyc(1'($urandom), 7'($urandom), 3'($urandom), zero, c, "branch");
    end else begin
      c.reg_write  = 1'b1;
      c.mem_to_reg = 2'b10;
      c.pc_write   = 1'b1;
      c.pc_src     = 1'b1;
      cycj(1'($urandom), c, "jal");
    end
    retired++;
    check("instret", 64'(o_instret), exp_instret());
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t c;
    do_reset();

    // Directed: one of each class, then maximum legal stalls.
    run_instr(OPC_LOAD, 3'b011, 1'b0, 0, 0);
    run_instr(OPC_STORE, 3'b011, 1'b0, 0, 3);
    run_instr(OPC_BRANCH, 3'b000, 1'b1, 0, 0);
    run_instr(OPC_BRANCH, 3'b001, 1'b1, 0, 0);
    run_instr(OPC_JAL, 3'b000, 1'b0, 0, 0);
    run_instr(OPC_OP, 3'b101, 1'b0, 0, 0);
    run_instr(OPC_LOAD, 3'b000, 1'b0, 3, 3);

    // Random legal traffic; enough retires to wrap the 8-bit counter.
    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [6:0]  opc;
      logic [2:0]  f3;
      kind = int'($urandom_range(0, 5));
      f3   = 3'($urandom);
      case (kind)
        0:       opc = OPC_LOAD;
        1:       opc = OPC_STORE;
        2:       opc = OPC_OP;
        3:       begin opc = OPC_BRANCH; f3 = 3'b000; end
        4:       begin opc = OPC_BRANCH; f3 = 3'b001; end
        default: opc = OPC_JAL;
      endcase
      run_instr(opc, f3, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Illegal opcode: halt with cause 01, ignore memory, keep instret.
    fetch_decode(7'b1111111, 3'b000, 0);
    for (int i = 0; i < 5; i++) cycj(1'($urandom), trap_c(2'b01), "trap_illegal");
    check("trap_instret", 64'(o_instret), exp_instret());

    // Unimplemented branch funct3 is illegal too.
    do_reset();
    fetch_decode(OPC_BRANCH, 3'b010, 1);
    for (int i = 0; i < 2; i++) cycj(1'b1, trap_c(2'b01), "trap_bad_f3");

    // Fetch timeout on the 4th stalled cycle.
    do_reset();
    for (int i = 0; i < 4; i++) cycj(1'b0, fetch_c(1'b0), "to_fetch_wait");
    for (int i = 0; i < 3; i++) cycj(1'($urandom), trap_c(2'b10), "trap_timeout");

    // Ready on the 4th cycle completes normally.
    do_reset();
    run_instr(OPC_JAL, 3'b000, 1'b0, 3, 0);

    // Memory-phase timeout on a store.
    do_reset();
    fetch_decode(OPC_STORE, 3'b010, 0);
    c = '0;
    c.alu_src = 1'b1;
    cycj(1'b0, c, "mto_exec");
    c = '0;
    c.mem_req = 1'b1;
    c.mem_we  = 1'b1;
    for (int i = 0; i < 4; i++) cycj(1'b0, c, "mto_mem_wait");
    for (int i = 0; i < 2; i++) cycj(1'b1, trap_c(2'b10), "trap_mem_timeout");
    check("mto_instret", 64'(o_instret), exp_instret());

    // Reset during a store's memory phase: no retire, back to IDLE.
    do_reset();
    fetch_decode(OPC_STORE, 3'b011, 0);
    c = '0;
    c.alu_src = 1'b1;
    cycj(1'b0, c, "rs_exec");
    c = '0;
    c.mem_req = 1'b1;
    c.mem_we  = 1'b1;
    cycj(1'b0, c, "rs_mem_wait");
    rst       = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rs_mem_hold", 64'(obs), 64'(c));
    @(posedge clk);
    #1;
    check("rs_idle_outputs", 64'(obs), 64'(0));
    check("rs_instret", 64'(o_instret), exp_instret());
    rst = 1'b0;
    cycj(1'b1, '0, "rs_idle");
    run_instr(OPC_OP, 3'b000, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
